main_car_scheduler: RTL and testbench
=====================================

# main_car_scheduler

Request scheduler and motion sequencer for the main elevator car. It latches floor requests from inside and outside the car into a pending set and serves them in SCAN order: the car keeps its direction while requests remain ahead of it. It drives the car's up/down motion, door and current-floor outputs. It sits between the request inputs and the main car's floor-display/motion logic in `top`.

## Interface
- `FLOORS`, 9: number of floors served; bit i of every request vector is floor i+1.
- `TRAVEL_CYCLES`, 4: clock cycles to travel one floor.
- `DWELL_CYCLES`, 6: clock cycles the door stays open with no sensor trip.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `internal_requests` in FLOORS: in-car buttons; level or pulse; any high bit is OR-ed into pending each cycle.
- `external_requests` in FLOORS: hall-call buttons; same handling as `internal_requests`.
- `sensor_trip` in 1: door obstruction; restarts the dwell time.
- `hold` in 1: maintenance/temperature stop; freezes motion.
- `move_up` out 1: car travelling up.
- `move_down` out 1: car travelling down.
- `door_open` out 1: door open at the current floor.
- `floor` out 4: current floor, binary, range 1..FLOORS.
- `pending` out FLOORS: outstanding request set.
- `busy` out 1: state is not IDLE, or `pending` is nonzero.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. Internal direction flag `dir_up`.
- Pending: `pending <= (pending | internal_requests | external_requests) & ~clr`.
  - `clr` is the current-floor bit whenever the state is DOOR or the car is entering DOOR.
  - A request for the current floor raised while the door is open is absorbed and never latched.
- IDLE, evaluated in this priority order:
  - pending[floor] set → DOOR.
  - Pending above and (`dir_up`, or none below) → MOVE_UP, `dir_up=1`.
  - Pending below → MOVE_DOWN, `dir_up=0`.
  - Otherwise stay in IDLE.
  - `hold` blocks both MOVE transitions; the DOOR transition is still allowed.
- MOVE_UP / MOVE_DOWN:
  - Travel counter counts TRAVEL_CYCLES. At terminal count `floor` changes by ±1 and the counter reloads.
  - On that same edge: next floor pending → DOOR; otherwise stay in the MOVE state.
  - `hold` freezes the counter and `floor` and deasserts the move output; motion resumes where it stopped when `hold` falls.
  - `floor` never leaves 1..FLOORS. A target always exists, because pending bits clear only in DOOR.
- DOOR:
  - Dwell counter runs DWELL_CYCLES.
  - `sensor_trip` high reloads the counter, so the door stays open DWELL_CYCLES after the last trip cycle.
  - On expiry → IDLE. `hold` has no effect in DOOR.
- Outputs are registered decodes of state:
  - `move_up` = MOVE_UP & ~hold.
  - `move_down` = MOVE_DOWN & ~hold.
  - `door_open` = DOOR.
  - `move_up`, `move_down` and `door_open` are mutually exclusive.
- Reset, including mid-move or with the door open: state IDLE, `floor=1`, `pending=0`, `dir_up=1`, all counters 0, all outputs 0 (`floor` reads 1).

## Timing
- Request high at edge k → visible in `pending` after k → IDLE decision at edge k+1 → `move_*` or `door_open` high after k+1.
- One floor takes exactly TRAVEL_CYCLES cycles of un-held motion.
- The door opens on the same edge `floor` reaches the target.
- `door_open` lasts DWELL_CYCLES cycles without trips.
- DOOR→IDLE takes one cycle. The next departure occurs at the following edge, so there is one IDLE cycle between door close and motion.
- Requests arriving in the same cycle as a floor update are considered at the next evaluation, not the current one.

## Structure
- Shared package `elevator_pkg` holds:
  - State enum: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
  - `FLOORS` default.
  - Floor width constant, 4.
  - The "any pending above/below floor f" helper function.
- One sub-module, `sched_timer`: loadable down-counter with `load`, `en` and `done`. Instantiated twice, once for travel and once for dwell.

## Test plan
- Reset, then pulse `external_requests=9'b000001000` → `move_up` high for 12 cycles, `floor` steps 1→2→3→4 every 4 cycles, `door_open` for 6 cycles, `pending=0`, back to IDLE.
- At floor 4, idle with `dir_up=1`, pulse `internal_requests[6]` and `external_requests[0]` together → car goes up to 7 first (door opens), then down to 1; `move_down` high for 24 cycles.
- `sensor_trip` pulsed on door cycles 3 and 7 → `door_open` high until 6 cycles after cycle 7, 13 cycles total.
- `hold` high for 5 cycles during MOVE_UP after 2 travel cycles → `move_up` low and `floor` frozen; the floor change lands exactly 2 un-held cycles after `hold` falls.
- In IDLE at floor 1, request floor 1 → `door_open` next cycle, no move output ever asserted; re-requesting floor 1 during DOOR leaves `pending[0]=0`.
- Assert `reset` while travelling 5→6 with `pending=9'b110000000` → next cycle `floor=1`, `pending=0`, all outputs 0; the car stays idle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and floor-set helpers for the elevator car logic.
// Request sets are handled at MAX_FLOORS width so the helpers serve any car size.
package elevator_pkg;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} carState_t;

  localparam int NUM_FLOORS = 9;
  localparam int FLOOR_W    = 4;
  localparam int MAX_FLOORS = (1 << FLOOR_W) - 1;
  localparam int TIMER_W    = 8;

  // Bit i of a request set stands for floor i+1.
  function automatic logic anyAbove(input logic [MAX_FLOORS-1:0] pend,
                                    input logic [FLOOR_W-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i + 1 > int'(f)) && pend[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic anyBelow(input logic [MAX_FLOORS-1:0] pend,
                                    input logic [FLOOR_W-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i + 1 < int'(f)) && pend[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] floorMask(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i + 1 == int'(f)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic isPending(input logic [MAX_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0] f);
    return |(pend & floorMask(f));
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module sched_timer
  import elevator_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_loadValue,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/main_car_scheduler.sv
// SCAN-order request scheduler and motion sequencer for the main elevator car.
// Pending requests are latched every cycle; the car keeps direction while requests lie ahead.
module main_car_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS        = NUM_FLOORS,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DWELL_CYCLES  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  internal_requests,
  input  logic [FLOORS-1:0]  external_requests,
  input  logic               sensor_trip,
  input  logic               hold,
  output logic               move_up,
  output logic               move_down,
  output logic               door_open,
  output logic [FLOOR_W-1:0] floor,
  output logic [FLOORS-1:0]  pending,
  output logic               busy
);

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DWELL_LOAD  = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS);

  carState_t              r_state;
  carState_t              w_stateNext;
  logic                   r_dirUp;
  logic                   w_dirUpNext;
  logic [FLOOR_W-1:0]     w_floorNext;
  logic [MAX_FLOORS-1:0]  w_pendWide;
  logic [FLOORS-1:0]      w_clr;
  logic                   w_step;
  logic                   w_nextIsMove;
  logic                   w_travelLoad;
  logic                   w_travelEn;
  logic                   w_travelDone;
  logic                   w_dwellLoad;
  logic                   w_dwellEn;
  logic                   w_dwellDone;

  assign w_pendWide = MAX_FLOORS'(pending);

  // Decisions look only at the latched pending set, so a request arriving on a
  // floor-update edge is seen at the following evaluation.
  always_comb begin
    w_stateNext = r_state;
    w_dirUpNext = r_dirUp;
    w_floorNext = floor;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (isPending(w_pendWide, floor)) begin
          w_stateNext = DOOR;
        end else if (!hold && anyAbove(w_pendWide, floor) &&
                     (r_dirUp || !anyBelow(w_pendWide, floor))) begin
          w_stateNext = MOVE_UP;
          w_dirUpNext = 1'b1;
        end else if (!hold && anyBelow(w_pendWide, floor)) begin
          w_stateNext = MOVE_DOWN;
          w_dirUpNext = 1'b0;
        end
      end
      MOVE_UP: begin
        if (!hold && w_travelDone) begin
          if (floor >= TOP_FLOOR) begin
            w_stateNext = IDLE;
          end else begin
            w_step      = 1'b1;
            w_floorNext = floor + 1'b1;
            if (isPending(w_pendWide, w_floorNext)) w_stateNext = DOOR;
          end
        end
      end
      MOVE_DOWN: begin
        if (!hold && w_travelDone) begin
          if (floor <= FLOOR_W'(1)) begin
            w_stateNext = IDLE;
          end else begin
            w_step      = 1'b1;
            w_floorNext = floor - 1'b1;
            if (isPending(w_pendWide, w_floorNext)) w_stateNext = DOOR;
          end
        end
      end
      DOOR: begin
        if (!sensor_trip && w_dwellDone) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_nextIsMove = (w_stateNext == MOVE_UP) || (w_stateNext == MOVE_DOWN);
  assign w_travelLoad = w_nextIsMove && ((r_state == IDLE) || w_step);
  assign w_travelEn   = ((r_state == MOVE_UP) || (r_state == MOVE_DOWN)) && !hold;
  assign w_dwellLoad  = (w_stateNext == DOOR) && ((r_state != DOOR) || sensor_trip);
  assign w_dwellEn    = (r_state == DOOR);

  // The floor being served is cleared while the door is open or opening.
  assign w_clr = ((r_state == DOOR) || (w_stateNext == DOOR)) ?
                 FLOORS'(floorMask(w_floorNext)) : '0;

  sched_timer #(.W(TIMER_W)) u_travelTimer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_travelLoad),
    .i_en        (w_travelEn),
    .i_loadValue (TRAVEL_LOAD),
    .o_done      (w_travelDone)
  );

  sched_timer #(.W(TIMER_W)) u_dwellTimer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_dwellLoad),
    .i_en        (w_dwellEn),
    .i_loadValue (DWELL_LOAD),
    .o_done      (w_dwellDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_dirUp   <= 1'b1;
      floor     <= FLOOR_W'(1);
      pending   <= '0;
      move_up   <= 1'b0;
      move_down <= 1'b0;
      door_open <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_dirUp   <= w_dirUpNext;
      floor     <= w_floorNext;
      pending   <= (pending | internal_requests | external_requests) & ~w_clr;
      move_up   <= (w_stateNext == MOVE_UP) && !hold;
      move_down <= (w_stateNext == MOVE_DOWN) && !hold;
      door_open <= (w_stateNext == DOOR);
    end
  end

  assign busy = (r_state != IDLE) || (|pending);

endmodule

// File: tb/tb_main_car_scheduler.sv
// Self-checking bench for main_car_scheduler: scripted vector table, hand-written
// corner sequences, then randomized traffic against a timing-rule reference model.
module tb_main_car_scheduler;

  localparam int FLOORS = 9;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [FLOORS-1:0] internal_requests = '0;
  logic [FLOORS-1:0] external_requests = '0;
  logic              sensor_trip = 1'b0;
  logic              hold = 1'b0;
  logic              move_up;
  logic              move_down;
  logic              door_open;
  logic [3:0]        floor;
  logic [FLOORS-1:0] pending;
  logic              busy;

  int testsRun    = 0;
  int testsFailed = 0;

  main_car_scheduler #(
    .FLOORS        (FLOORS),
    .TRAVEL_CYCLES (TRAVEL),
    .DWELL_CYCLES  (DWELL)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .internal_requests (internal_requests),
    .external_requests (external_requests),
    .sensor_trip       (sensor_trip),
    .hold              (hold),
    .move_up           (move_up),
    .move_down         (move_down),
    .door_open         (door_open),
    .floor             (floor),
    .pending           (pending),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic [FLOORS-1:0] intReq;
    logic [FLOORS-1:0] extReq;
    int                edges;
    logic [3:0]        expFloor;
    logic [FLOORS-1:0] expPend;
    logic              expUp;
    logic              expDown;
    logic              expDoor;
    logic              expBusy;
  } vec_t;

  vec_t vecs[20];

  // Reference model state: phase 0 idle, 1 up, 2 down, 3 door; elapsed counts up.
  int mPhase, mFloor, mPend, mElapsed;
  bit mDir, mUp, mDown, mDoor;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Inputs are held for the first edge of the row only, then released.
  task automatic applyStimulus(input vec_t v);
    reset             = v.rst;
    internal_requests = v.intReq;
    external_requests = v.extReq;
    tick();
    reset             = 1'b0;
    internal_requests = '0;
    external_requests = '0;
    repeat (v.edges - 1) tick();
  endtask

  task automatic modelStep(input int req, input bit trip, input bit hld, input bit rst);
    int  nPend;
    bit  wasDoor;
    bit  above;
    bit  below;
    if (rst) begin
      mPhase = 0; mFloor = 1; mPend = 0; mDir = 1'b1; mElapsed = 0;
      mUp = 1'b0; mDown = 1'b0; mDoor = 1'b0;
      return;
    end
    wasDoor = (mPhase == 3);
    nPend   = mPend | req;
    above   = (mPend >> mFloor) != 0;
    below   = (mPend & ((1 << (mFloor - 1)) - 1)) != 0;
    case (mPhase)
      0: begin
        if (((mPend >> (mFloor - 1)) & 1) != 0) begin
          mPhase = 3; mElapsed = 0;
        end else if (!hld && above && (mDir || !below)) begin
          mPhase = 1; mDir = 1'b1; mElapsed = 0;
        end else if (!hld && below) begin
          mPhase = 2; mDir = 1'b0; mElapsed = 0;
        end
      end
      1, 2: begin
        if (!hld) begin
          mElapsed++;
          if (mElapsed == TRAVEL) begin
            mFloor   = (mPhase == 1) ? mFloor + 1 : mFloor - 1;
            mElapsed = 0;
            if (((mPend >> (mFloor - 1)) & 1) != 0) mPhase = 3;
          end
        end
      end
      default: begin
        if (trip) begin
          mElapsed = 0;
        end else begin
          mElapsed++;
          if (mElapsed == DWELL) begin
            mPhase = 0; mElapsed = 0;
          end
        end
      end
    endcase
    if (wasDoor || mPhase == 3) nPend = nPend & ~(1 << (mFloor - 1));
    mPend = nPend;
    mUp   = (mPhase == 1) && !hld;
    mDown = (mPhase == 2) && !hld;
    mDoor = (mPhase == 3);
  endtask

  initial begin
    int holdLeft;
    logic [FLOORS-1:0] ir;
    logic [FLOORS-1:0] er;
    logic tr;
    logic hd;
    logic rs;

    // rst, int, ext, edges, floor, pending, up, down, door, busy
    vecs[0]  = '{1'b1, 9'h000, 9'h000, 1,  4'd1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 9'h000, 9'h008, 1,  4'd1, 9'h008, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 9'h000, 9'h000, 1,  4'd1, 9'h008, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 9'h000, 9'h000, 3,  4'd1, 9'h008, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 9'h000, 9'h000, 1,  4'd2, 9'h008, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 9'h000, 9'h000, 8,  4'd4, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 9'h000, 9'h000, 5,  4'd4, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 9'h000, 9'h000, 1,  4'd4, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 9'h040, 9'h001, 1,  4'd4, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 9'h000, 9'h000, 1,  4'd4, 9'h041, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 9'h000, 9'h000, 12, 4'd7, 9'h001, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 9'h000, 9'h000, 6,  4'd7, 9'h001, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 9'h000, 9'h000, 1,  4'd7, 9'h001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 9'h000, 9'h000, 23, 4'd2, 9'h001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 9'h000, 9'h000, 1,  4'd1, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 9'h000, 9'h000, 6,  4'd1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 9'h001, 9'h000, 1,  4'd1, 9'h001, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 9'h000, 9'h000, 1,  4'd1, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 9'h000, 9'h001, 1,  4'd1, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 9'h000, 9'h000, 5,  4'd1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d floor", i), 32'(floor), 32'(vecs[i].expFloor));
      checkOutput($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].expPend));
      checkOutput($sformatf("vec%0d move_up", i), 32'(move_up), 32'(vecs[i].expUp));
      checkOutput($sformatf("vec%0d move_down", i), 32'(move_down), 32'(vecs[i].expDown));
      checkOutput($sformatf("vec%0d door_open", i), 32'(door_open), 32'(vecs[i].expDoor));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
    end

    // Sensor trips on door cycles 3 and 7 stretch the door to 13 cycles.
    internal_requests = 9'h001;
    tick();
    internal_requests = '0;
    tick();
    checkOutput("trip door opens", 32'(door_open), 32'd1);
    for (int c = 1; c <= 14; c++) begin
      sensor_trip = (c == 3) || (c == 7);
      tick();
      sensor_trip = 1'b0;
      checkOutput($sformatf("trip door cycle %0d", c), 32'(door_open), 32'(c <= 12));
    end

    // Hold for five edges after two travel cycles towards floor 3.
    external_requests = 9'h004;
    tick();
    external_requests = '0;
    tick();
    checkOutput("hold depart", 32'(move_up), 32'd1);
    tick();
    tick();
    hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("hold move_up %0d", c), 32'(move_up), 32'd0);
      checkOutput($sformatf("hold floor %0d", c), 32'(floor), 32'd1);
    end
    hold = 1'b0;
    tick();
    checkOutput("hold resume move_up", 32'(move_up), 32'd1);
    checkOutput("hold resume floor", 32'(floor), 32'd1);
    tick();
    checkOutput("hold floor lands", 32'(floor), 32'd2);
    repeat (4) tick();
    checkOutput("hold reach floor3", 32'(floor), 32'd3);
    checkOutput("hold door floor3", 32'(door_open), 32'd1);
    repeat (6) tick();
    checkOutput("hold door closed", 32'(door_open), 32'd0);

    // Reset while travelling 5 to 6 with floors 8 and 9 pending.
    external_requests = 9'h180;
    tick();
    external_requests = '0;
    repeat (10) tick();
    checkOutput("midmove floor", 32'(floor), 32'd5);
    checkOutput("midmove pending", 32'(pending), 32'h180);
    checkOutput("midmove moving", 32'(move_up), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset floor", 32'(floor), 32'd1);
    checkOutput("reset pending", 32'(pending), 32'd0);
    checkOutput("reset outputs", 32'({move_up, move_down, door_open, busy}), 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput($sformatf("reset stays idle %0d", c),
                  32'({floor, move_up, move_down, door_open, busy}), 32'h10);
    end

    // Randomized traffic against the reference model.
    holdLeft = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ir = '0;
      er = '0;
      if ($urandom_range(0, 9) == 0) ir[$urandom_range(0, FLOORS - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) er[$urandom_range(0, FLOORS - 1)] = 1'b1;
      tr = ($urandom_range(0, 7) == 0);
      if (holdLeft > 0) begin
        hd = 1'b1;
        holdLeft--;
      end else begin
        hd = 1'b0;
        if ($urandom_range(0, 59) == 0) holdLeft = $urandom_range(1, 6);
      end
      rs = (cyc == 0) || ($urandom_range(0, 499) == 0);
      internal_requests = ir;
      external_requests = er;
      sensor_trip       = tr;
      hold              = hd;
      reset             = rs;
      modelStep(int'(ir | er), tr, hd, rs);
      tick();
      checkOutput($sformatf("rand cyc %0d {floor,pend,up,dn,door,busy}", cyc),
                  32'({floor, pending, move_up, move_down, door_open, busy}),
                  32'({4'(mFloor), 9'(mPend), mUp, mDown, mDoor,
                       (mPhase != 0) || (mPend != 0)}));
      checkOutput($sformatf("rand cyc %0d exclusive", cyc),
                  32'($onehot0({move_up, move_down, door_open})), 32'd1);
    end
    internal_requests = '0;
    external_requests = '0;
    sensor_trip       = 1'b0;
    hold              = 1'b0;
    reset             = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
